// File: rtl/store_wbuf_pkg.sv
// store_wbuf_pkg: shared store-control and drain-state encodings for the store write buffer.
`ifndef STORE_WBUF_DEFINES
`define STORE_WBUF_DEFINES
`define SB_CONTROL 6'b101000
`define SH_CONTROL 6'b101001
`define SW_CONTROL 6'b101011
`define WB_IDLE 2'd0
`define WB_REQ 2'd1
`define WB_WAIT 2'd2
`endif
package store_wbuf_pkg;
  localparam logic [5:0] SB_C = `SB_CONTROL;
  localparam logic [5:0] SH_C = `SH_CONTROL;
  localparam logic [5:0] SW_C = `SW_CONTROL;
  typedef enum logic [1:0] {
    ST_IDLE = `WB_IDLE,
    ST_REQ  = `WB_REQ,
    ST_WAIT = `WB_WAIT
  } wb_state_e;
  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: alignment check and byte-lane strobe/data placement for SB/SH/SW.
module store_lane_align
  import store_wbuf_pkg::*;
(
  input  logic [5:0]  ctrl_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wd_i,
  output logic        err_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);
  logic sb, sh, sw;
  assign sb = ctrl_i == SB_C;
  assign sh = ctrl_i == SH_C;
  assign sw = ctrl_i == SW_C;
  assign err_o = (sw & |off_i) | (sh & off_i[0]);
  assign wstrb_o = sw ? 4'b1111 : sh ? (off_i[1] ? 4'b0011 : 4'b1100) : sb ? 4'b1000 >> off_i : 4'b0000;
  // Replicate the source across all lanes, then keep only the enabled ones.
  assign wdata_o = (sw ? wd_i : sh ? {2{wd_i[15:0]}} : {4{wd_i[7:0]}}) & lane_mask(wstrb_o);
endmodule

// File: rtl/store_wbuf.sv
// store_wbuf: MEM-stage store buffer; aligns stores, queues them and drains one at a time
// over the req/addr_ok/data_ok bus.
module store_wbuf
  import store_wbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          store_validM,
  input  logic [5:0]    alucontrolM,
  input  logic [AW-1:0] aluoutM,
  input  logic [31:0]   writedataM,
  input  logic          flushM,
  input  logic          load_validM,
  output logic          saddrerrM,
  output logic [AW-1:0] badvaddrM,
  output logic          stallM,
  output logic          wbuf_empty,
  output logic          data_req,
  output logic          data_wr,
  output logic [3:0]    data_wstrb,
  output logic [AW-1:0] data_addr,
  output logic [31:0]   data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-3:0] addr_q [DEPTH];
  logic [3:0] strb_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0] cnt_q, cnt_d;
  wb_state_e st_q, st_d;
  logic err, full, push, pop, hit;
  logic [3:0] strb;
  logic [31:0] wdata;
  store_lane_align u_align (
    .ctrl_i (alucontrolM),
    .off_i  (aluoutM[1:0]),
    .wd_i   (writedataM),
    .err_o  (err),
    .wstrb_o(strb),
    .wdata_o(wdata)
  );
  assign saddrerrM = store_validM & err;
  assign badvaddrM = saddrerrM ? aluoutM : '0;
  assign full = cnt_q == (PW+1)'(DEPTH);
  assign push = store_validM & ~err & ~flushM & ~full;
  assign pop = (st_q == ST_REQ & data_addr_ok & data_data_ok) | (st_q == ST_WAIT & data_data_ok);
  assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  assign stallM = (store_validM & ~flushM & ~saddrerrM & full) | (load_validM & hit);
  assign wbuf_empty = (cnt_q == '0) & (st_q == ST_IDLE);
  assign data_req = st_q == ST_REQ;
  assign data_wr = 1'b1;
  assign data_addr = {addr_q[rptr_q], 2'b00};
  assign data_wstrb = strb_q[rptr_q];
  assign data_wdata = data_q[rptr_q];
  // The in-flight entry stays in the FIFO until data_ok, so scanning valid slots covers it.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if ((PW+1)'(PW'(i) - rptr_q) < cnt_q && addr_q[i] == aluoutM[AW-1:2]) hit = 1'b1;
  end
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: st_d = (cnt_q != '0) ? ST_REQ : ST_IDLE;
      ST_REQ:  st_d = !data_addr_ok ? ST_REQ : !data_data_ok ? ST_WAIT : (cnt_d != '0) ? ST_REQ : ST_IDLE;
      ST_WAIT: st_d = !data_data_ok ? ST_WAIT : (cnt_d != '0) ? ST_REQ : ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      st_q <= ST_IDLE;
    end else begin
      cnt_q <= cnt_d;
      st_q <= st_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr_q] <= aluoutM[AW-1:2];
      strb_q[wptr_q] <= strb;
      data_q[wptr_q] <= wdata;
    end
  end
endmodule

// File: tb/tb_store_wbuf.sv
// tb_store_wbuf: scoreboard bench; expected bus writes are queued as stores are issued and
// compared when the DUT requests the bus.
module tb_store_wbuf;
  import store_wbuf_pkg::*;
  logic clk = 1'b0;
  logic rst, store_validM, flushM, load_validM;
  logic [5:0] alucontrolM;
  logic [31:0] aluoutM, writedataM, badvaddrM, data_addr, data_wdata;
  logic saddrerrM, stallM, wbuf_empty, data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0] data_wstrb;
  int checks = 0, errors = 0, n_done = 0, base;
  logic [67:0] sb_q [$];
  logic bus_en = 1'b1, split = 1'b0, hold_dok = 1'b0, pend = 1'b0;
  always #5 clk = ~clk;
  store_wbuf #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst(rst), .store_validM(store_validM), .alucontrolM(alucontrolM),
    .aluoutM(aluoutM), .writedataM(writedataM), .flushM(flushM), .load_validM(load_validM),
    .saddrerrM(saddrerrM), .badvaddrM(badvaddrM), .stallM(stallM), .wbuf_empty(wbuf_empty),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Bus slave: accepts on the negedge after data_req; data_ok same cycle or one later.
  initial begin
    logic [67:0] e;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    forever begin
      @(negedge clk);
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      if (rst) pend = 1'b0;
      else if (pend) begin
        if (!hold_dok) begin
          data_data_ok = 1'b1;
          pend = 1'b0;
          n_done++;
        end
      end else if (data_req && bus_en) begin
        if (sb_q.size() == 0) chk("spurious_req", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("addr", data_addr, e[67:36]);
          chk("strb", data_wstrb, e[35:32]);
          chk("wdata", data_wdata, e[31:0]);
        end
        data_addr_ok = 1'b1;
        if (split) pend = 1'b1;
        else begin
          data_data_ok = 1'b1;
          n_done++;
        end
      end
    end
  end
  task automatic st(input logic [5:0] c, input logic [31:0] a, input logic [31:0] wd, input logic fl,
                    input logic exp_err, input logic exp_stall, input logic [3:0] es, input logic [31:0] ed);
    int n = 0;
    @(negedge clk);
    store_validM = 1'b1;
    alucontrolM = c;
    aluoutM = a;
    writedataM = wd;
    flushM = fl;
    load_validM = 1'b0;
    #1;
    chk("saddrerr", saddrerrM, exp_err);
    chk("badvaddr", badvaddrM, exp_err ? a : 32'h0);
    if (exp_stall) begin
      chk("stall_full", stallM, 1);
      bus_en = 1'b1;
    end
    while (stallM && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n == 100) chk("stall_timeout", 1, 0);
    if (!exp_err && !fl) sb_q.push_back({a & ~32'h3, es, ed});
    @(posedge clk);
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    store_validM = 1'b0;
    load_validM = 1'b0;
    flushM = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic drain();
    int n = 0;
    idle(0);
    while ((!wbuf_empty || sb_q.size() != 0 || pend) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drained", wbuf_empty, 1);
    chk("sb_empty", 64'(sb_q.size()), 0);
  endtask
  initial begin
    rst = 1'b1;
    store_validM = 1'b0;
    flushM = 1'b0;
    load_validM = 1'b0;
    alucontrolM = '0;
    aluoutM = '0;
    writedataM = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", data_req, 0);
    chk("rst_empty", wbuf_empty, 1);
    chk("rst_stall", stallM, 0);
    chk("data_wr", data_wr, 1);
    rst = 1'b0;
    st(SB_C, 32'h100, 32'h000000AB, 0, 0, 0, 4'b1000, 32'hAB000000);
    st(SB_C, 32'h103, 32'h000000AB, 0, 0, 0, 4'b0001, 32'h000000AB);
    st(SB_C, 32'h101, 32'h123456CD, 0, 0, 0, 4'b0100, 32'h00CD0000);
    drain();
    st(SH_C, 32'h1001, 32'h00001234, 0, 1, 0, 4'b0000, 32'h0);
    idle(1);
    chk("err_empty", wbuf_empty, 1);
    chk("err_noreq", data_req, 0);
    st(SH_C, 32'h1002, 32'h00001234, 0, 0, 0, 4'b0011, 32'h00001234);
    st(SH_C, 32'h1000, 32'hABCD1234, 0, 0, 0, 4'b1100, 32'h12340000);
    st(SW_C, 32'h2002, 32'h55555555, 0, 1, 0, 4'b0000, 32'h0);
    drain();
    base = n_done;
    bus_en = 1'b0;
    for (int k = 0; k < 4; k++)
      st(SW_C, 32'(4 * k), 32'h11111111 * (k + 1), 0, 0, 0, 4'b1111, 32'h11111111 * (k + 1));
    st(SW_C, 32'h10, 32'hCAFEF00D, 0, 0, 1, 4'b1111, 32'hCAFEF00D);
    drain();
    chk("fifo_writes", 64'(n_done - base), 5);
    split = 1'b1;
    hold_dok = 1'b1;
    st(SW_C, 32'h20, 32'hDEADBEEF, 0, 0, 0, 4'b1111, 32'hDEADBEEF);
    idle(3);
    chk("wait_noreq", data_req, 0);
    base = n_done;
    load_validM = 1'b1;
    aluoutM = 32'h24;
    #1;
    chk("ld_nohit", stallM, 0);
    aluoutM = 32'h22;
    #1;
    chk("ld_hit", stallM, 1);
    hold_dok = 1'b0;
    for (int n = 0; n < 20 && stallM; n++) begin
      @(negedge clk);
      #1;
    end
    chk("ld_release", stallM, 0);
    chk("ld_done", 64'(n_done - base), 1);
    drain();
    split = 1'b0;
    base = n_done;
    st(SW_C, 32'h40, 32'h0BADF00D, 1, 0, 0, 4'b1111, 32'h0);
    idle(3);
    chk("flush_empty", wbuf_empty, 1);
    chk("flush_nowrite", 64'(n_done - base), 0);
    bus_en = 1'b0;
    st(SW_C, 32'h50, 32'hA5A5A5A5, 0, 0, 0, 4'b1111, 32'hA5A5A5A5);
    st(SW_C, 32'h54, 32'h5A5A5A5A, 0, 0, 0, 4'b1111, 32'h5A5A5A5A);
    st(SW_C, 32'h58, 32'hFFFFFFFF, 1, 0, 0, 4'b1111, 32'h0);
    bus_en = 1'b1;
    drain();
    chk("flush_drain", 64'(n_done - base), 2);
    split = 1'b1;
    hold_dok = 1'b1;
    for (int k = 0; k < 3; k++)
      st(SW_C, 32'h60 + 32'(4 * k), 32'h600 + 32'(k), 0, 0, 0, 4'b1111, 32'h600 + 32'(k));
    idle(4);
    chk("pre_rst_req", data_req, 0);
    chk("pre_rst_busy", wbuf_empty, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", data_req, 0);
    chk("mid_rst_empty", wbuf_empty, 1);
    chk("mid_rst_stall", stallM, 0);
    rst = 1'b0;
    pend = 1'b0;
    sb_q.delete();
    hold_dok = 1'b0;
    split = 1'b0;
    base = n_done;
    st(SW_C, 32'h70, 32'h77777777, 0, 0, 0, 4'b1111, 32'h77777777);
    drain();
    chk("post_rst_write", 64'(n_done - base), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_wbuf.md
Name: store_wbuf

Overview:
- Store-side counterpart of the load-extraction path in the MIPS pipeline; sits at the MEM stage between the datapath and the data-memory bus.
- Checks store alignment and converts SB/SH/SW into a byte-lane strobe and a lane-shifted write word.
- Buffers committed stores in a small FIFO and drains them to memory over a req/addr_ok/data_ok handshake.
- Stalls the pipeline when the FIFO is full, or when a load hits a word that is still pending.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- AW, 32, address width.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- store_validM  input  1  MEM-stage instruction is a store.
- alucontrolM  input  6  one of `SB_CONTROL / `SH_CONTROL / `SW_CONTROL.
- aluoutM  input  AW  effective byte address.
- writedataM  input  32  register rt value.
- flushM  input  1  exception/flush: the MEM-stage store must not commit.
- load_validM  input  1  MEM-stage instruction is a load.
- saddrerrM  output  1  store address misaligned (combinational).
- badvaddrM  output  AW  faulting address; equals aluoutM when saddrerrM is high, else 0.
- stallM  output  1  hold the pipeline.
- wbuf_empty  output  1  no pending stores (used for SYNC/cache ops).
- data_req  output  1  bus request.
- data_wr  output  1  constant 1.
- data_wstrb  output  4  byte enables; bit3 = bits 31:24.
- data_addr  output  AW  word-aligned address, low 2 bits = 00.
- data_wdata  output  32  lane-shifted data.
- data_addr_ok  input  1  address accepted.
- data_data_ok  input  1  write completed.

Behaviour:
- Alignment rules:
  - SW requires aluoutM[1:0]==00.
  - SH requires aluoutM[0]==0.
  - SB is never misaligned.
  - saddrerrM is asserted only while store_validM is high.
- Lane mapping (offset 00 is the most-significant byte):
  - SB: offset 00/01/10/11 gives strobe 1000/0100/0010/0001; byte writedataM[7:0] is placed in lanes 31:24, 23:16, 15:8, 7:0 respectively.
  - SH: offset 00 gives strobe 1100 and data {wd[15:0],16'h0}; offset 10 gives strobe 0011 and data {16'h0,wd[15:0]}.
  - SW: strobe 1111, data as is.
  - Lanes that are not enabled are driven to 0.
- Enqueue condition: store_validM & ~saddrerrM & ~flushM & (count != DEPTH).
  - Each entry holds {word addr, wstrb, wdata}.
- Full rule: full is decided on the registered count. A pop in the same cycle does not free a slot for a same-cycle enqueue.
- stallM = (store_validM & ~flushM & ~saddrerrM & full) | load_conflict.
- load_conflict = load_validM & (some valid entry, or the in-flight entry, has word addr == aluoutM[AW-1:2]).
- Simultaneous enqueue and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Drain FSM, state encodings in the shared defines:
  - IDLE: if count != 0, go to REQ.
  - REQ: data_req=1, address/strobe/data come from the head entry and are held stable until data_addr_ok. On data_addr_ok go to WAIT.
  - WAIT: data_req=0. On data_data_ok, pop the head; go to REQ if count after the pop is nonzero, else IDLE.
  - data_addr_ok and data_data_ok together in REQ: treated as addr_ok, then data_ok; the entry pops that cycle and the FSM takes the WAIT exit directly.
- Ordering: strictly FIFO; at most one transaction outstanding.
- flushM only suppresses the current enqueue. Entries already buffered still drain.
- wbuf_empty = (count==0) & (state==IDLE).
- Reset (including mid-transaction): count=0, pointers=0, state=IDLE, data_req=0, stallM=0, wbuf_empty=1. Buffered stores are discarded; the system reset covers the bus side.

Decomposition:
- defines2.vh (shared): `SB_CONTROL/`SH_CONTROL/`SW_CONTROL (already present), plus new `WB_IDLE/`WB_REQ/`WB_WAIT state encodings.
- Sub-module store_lane_align: purely combinational. Maps alucontrolM, offset and writedataM to {saddrerr, wstrb, wdata}. The FIFO and FSM stay in store_wbuf.

Test Plan:
- SB addr 0x100, wd 0x000000AB, bus always ready -> data_addr 0x100, wstrb 1000, wdata 0xAB000000; SB addr 0x103 -> wstrb 0001, wdata 0x000000AB.
- SH addr 0x1001 -> saddrerrM=1, badvaddrM=0x1001, no enqueue, wbuf_empty stays 1; SH addr 0x1002, wd 0x1234 -> wstrb 0011, wdata 0x00001234.
- data_addr_ok held 0; issue 5 SW (addrs 0x0, 0x4, 0x8, 0xC, 0x10) -> stallM on the 5th; release the bus -> 4 writes in order, then the 5th enqueues and drains.
- SW 0x20 pending, then LW 0x22 -> stallM=1 until data_data_ok for 0x20; LW 0x24 -> no stall.
- SW with flushM=1 -> nothing enqueued, no bus activity; flush while 2 entries are buffered -> both still drain.
- rst asserted in WAIT with 3 entries -> next cycle data_req=0, wbuf_empty=1, and a new SW drains normally.
